readout_adc_fsm: RTL

- Readout/ADC sequencer on MOBO; consumes the frame-done handshake (FSMIND1) from the exposure FSM and returns FSMIND0 when readout is complete.
- Per row: selects row, settles, samples the signal level, triggers one ADC conversion, and emits the captured sample with a one-cycle valid strobe.
- All rows read once per frame, then control goes back to the exposure FSM.

---
 rtl/readout_adc_fsm.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/readout_adc_fsm.sv
// rtl/readout_adc_fsm.sv - per-frame row readout and ADC conversion sequencer
//
// Waits for the exposure FSM's frame-done request, walks every pixel row
// (select, settle, sample, convert), emits one sample per row, then hands
// control back with a readout-done request.
//
// Optional build macro: READOUT_CDS_EN
//   defined   - each row also samples and converts the reset level (SHR) and
//               DOUT carries signal minus reset, clamped at zero.
//   undefined - SHR is tied low and DOUT carries the raw ADC result.
//
// Ports:
//   CLK_HS      in   readout clock, rising edge
//   RESET_B     in   asynchronous active-low reset
//   FSMIND1     in   frame-done request from exposure FSM (asynchronous)
//   FSMIND1ACK  out  acknowledge of FSMIND1, held for the whole readout
//   FSMIND0     out  readout-done request to exposure FSM
//   FSMIND0ACK  in   acknowledge of FSMIND0 (asynchronous)
//   ROW_ADDR    out  row currently being read
//   ROW_SEL     out  row select enable
//   SHS         out  signal sample-and-hold
//   SHR         out  reset sample-and-hold
//   ADC_START   out  one-cycle conversion start
//   ADC_DONE    in   conversion complete (level or pulse)
//   ADC_DATA    in   conversion result, valid while ADC_DONE is high
//   DOUT        out  captured sample
//   DOUT_VALID  out  one-cycle strobe per captured sample
//   CntFrame    out  completed frame count
//   ADC_ERR     out  sticky ADC timeout flag
//   fsm_stat    out  debug state code
module readout_adc_fsm #(
    parameter int C_NUM_ROWS    = 160,
    parameter int C_ADC_W       = 12,
    parameter int C_SETTLE      = 8,
    parameter int C_SAMPLE      = 4,
    parameter int C_ADC_TIMEOUT = 1023
) (
    input  logic               CLK_HS,
    input  logic               RESET_B,
    input  logic               FSMIND1,
    output logic               FSMIND1ACK,
    output logic               FSMIND0,
    input  logic               FSMIND0ACK,
    output logic [7:0]         ROW_ADDR,
    output logic               ROW_SEL,
    output logic               SHS,
    output logic               SHR,
    output logic               ADC_START,
    input  logic               ADC_DONE,
    input  logic [C_ADC_W-1:0] ADC_DATA,
    output logic [C_ADC_W-1:0] DOUT,
    output logic               DOUT_VALID,
    output logic [31:0]        CntFrame,
    output logic               ADC_ERR,
    output logic [7:0]         fsm_stat
);

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(C_SETTLE - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(C_SAMPLE - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_MAX = CNT_W'(C_ADC_TIMEOUT);
    localparam logic [7:0]       ROW_LAST    = 8'(C_NUM_ROWS - 1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_ROW   = 4'd1,
        S_SHS   = 4'd2,
        S_CONV  = 4'd3,
        S_NEXT  = 4'd4,
        S_DONE  = 4'd5,
        S_SHR   = 4'd6,
        S_CONVR = 4'd7
    } state_t;

    state_t state, state_next;

    logic [1:0]       ind1_sync, ack0_sync;
    logic             ind1, ack0;
    logic [CNT_W-1:0] cnt;
    logic             start_frame, conv_hit, conv_to, row_adv, frame_end, done_exit;
    logic [C_ADC_W-1:0] sample_value;

    function automatic logic [7:0] stat_code(input state_t s);
        case (s)
            S_IDLE:  stat_code = 8'hF1;
            S_ROW:   stat_code = 8'hF2;
            S_SHS:   stat_code = 8'hF3;
            S_CONV:  stat_code = 8'hF4;
            S_NEXT:  stat_code = 8'hF5;
            S_DONE:  stat_code = 8'hF6;
            S_SHR:   stat_code = 8'hF7;
            S_CONVR: stat_code = 8'hF8;
            default: stat_code = 8'hAA;
        endcase
    endfunction

    // Both handshake inputs come from another board; only the second flop
    // of each chain is allowed to reach the FSM.
    always_ff @(posedge CLK_HS or negedge RESET_B) begin
        if (!RESET_B) begin
            ind1_sync <= 2'b00;
            ack0_sync <= 2'b00;
        end else begin
            ind1_sync <= {ind1_sync[0], FSMIND1};
            ack0_sync <= {ack0_sync[0], FSMIND0ACK};
        end
    end

    assign ind1 = ind1_sync[1];
    assign ack0 = ack0_sync[1];

`ifdef READOUT_CDS_EN
    logic [C_ADC_W-1:0] rst_sample;
    assign sample_value = (ADC_DATA > rst_sample) ? ADC_DATA - rst_sample : '0;
`else
    assign sample_value = ADC_DATA;
`endif

    always_ff @(posedge CLK_HS or negedge RESET_B) begin
        if (!RESET_B) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        conv_hit    = 1'b0;
        conv_to     = 1'b0;
        row_adv     = 1'b0;
        frame_end   = 1'b0;
        done_exit   = 1'b0;
        ROW_SEL     = 1'b0;
        SHS         = 1'b0;
        SHR         = 1'b0;
        ADC_START   = 1'b0;
        FSMIND0     = 1'b0;
        case (state)
            S_IDLE: begin
                // A still-high FSMIND0ACK means the previous handshake has not
                // fully closed; starting now could release the next frame early.
                if (ind1 && !ack0) begin
                    start_frame = 1'b1;
                    state_next  = S_ROW;
                end
            end
            S_ROW: begin
                ROW_SEL = 1'b1;
                if (cnt == SETTLE_LAST) begin
`ifdef READOUT_CDS_EN
                    state_next = S_SHR;
`else
                    state_next = S_SHS;
`endif
                end
            end
`ifdef READOUT_CDS_EN
            S_SHR: begin
                ROW_SEL = 1'b1;
                SHR     = 1'b1;
                if (cnt == SAMPLE_LAST) begin
                    state_next = S_CONVR;
                end
            end
            S_CONVR: begin
                ROW_SEL   = 1'b1;
                ADC_START = (cnt == '0);
                if (cnt != '0 && ADC_DONE) begin
                    conv_hit   = 1'b1;
                    state_next = S_SHS;
                end else if (cnt == TIMEOUT_MAX) begin
                    conv_to    = 1'b1;
                    state_next = S_SHS;
                end
            end
`endif
            S_SHS: begin
                ROW_SEL = 1'b1;
                SHS     = 1'b1;
                if (cnt == SAMPLE_LAST) begin
                    state_next = S_CONV;
                end
            end
            S_CONV: begin
                ROW_SEL   = 1'b1;
                ADC_START = (cnt == '0);
                // ADC_DONE is ignored in the start cycle so a level-style DONE
                // left over from the previous conversion is not mistaken for this one.
                if (cnt != '0 && ADC_DONE) begin
                    conv_hit   = 1'b1;
                    state_next = S_NEXT;
                end else if (cnt == TIMEOUT_MAX) begin
                    conv_to    = 1'b1;
                    state_next = S_NEXT;
                end
            end
            S_NEXT: begin
                row_adv = 1'b1;
                if (ROW_ADDR == ROW_LAST) begin
                    frame_end  = 1'b1;
                    state_next = S_DONE;
                end else begin
                    state_next = S_ROW;
                end
            end
            S_DONE: begin
                FSMIND0 = 1'b1;
                if (ack0 && !ind1) begin
                    done_exit  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // One counter serves settle, sample and ADC timeout; it restarts on every
    // state change so each phase starts counting from zero.
    always_ff @(posedge CLK_HS or negedge RESET_B) begin
        if (!RESET_B) begin
            cnt <= '0;
        end else if (state_next != state) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK_HS or negedge RESET_B) begin
        if (!RESET_B) begin
            FSMIND1ACK <= 1'b0;
            ROW_ADDR   <= '0;
            DOUT       <= '0;
            DOUT_VALID <= 1'b0;
            CntFrame   <= '0;
            ADC_ERR    <= 1'b0;
            fsm_stat   <= 8'hAA;
`ifdef READOUT_CDS_EN
            rst_sample <= '0;
`endif
        end else begin
            DOUT_VALID <= 1'b0;
            fsm_stat   <= stat_code(state_next);

            if (start_frame) begin
                FSMIND1ACK <= 1'b1;
                ROW_ADDR   <= '0;
            end
            if (done_exit) begin
                FSMIND1ACK <= 1'b0;
            end

            if (conv_to) begin
                ADC_ERR <= 1'b1;
            end

            // A timed-out row still produces a zero sample so downstream
            // always sees exactly one sample per row.
            if (state == S_CONV && (conv_hit || conv_to)) begin
                DOUT       <= conv_to ? '0 : sample_value;
                DOUT_VALID <= 1'b1;
            end
`ifdef READOUT_CDS_EN
            if (state == S_CONVR && (conv_hit || conv_to)) begin
                rst_sample <= conv_to ? '0 : ADC_DATA;
            end
`endif

            if (row_adv) begin
                if (frame_end) begin
                    ROW_ADDR <= '0;
                    CntFrame <= CntFrame + 32'd1;
                end else begin
                    ROW_ADDR <= ROW_ADDR + 8'd1;
                end
            end
        end
    end

endmodule
